// File: rtl/pulse_meter_pkg.sv
// Shared state encoding and default sizing for the pulse period meter.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam int          DEF_WIDTH     = 20;
  localparam int unsigned DEF_MAX_COUNT = 32'h000F_FFFF;

endpackage

// File: rtl/rise_edge_detect.sv
// One-cycle strobe on a 0->1 transition of an already-synchronous input.
// Combinational strobe from a single history flop; no backpressure.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (reset) din_q <= 1'b0;
    else       din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Edge-to-edge period meter; result registered one cycle after the edge, held until accepted.
// Unaccepted results are overwritten (sticky overrun); min/max tracking under PULSE_PERIOD_METER_MINMAX_EN.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout,
  output logic             overrun,
  output logic [WIDTH-1:0] min_period,
  output logic [WIDTH-1:0] max_period
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_inc;
  logic             rise, capture, at_max;

  rise_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (pulse_in),
    .rise  (rise)
  );

  // count+1 never exceeds MAX_COUNT, so the increment cannot wrap
  assign count_inc = count + WIDTH'(1);
  assign at_max    = (count_inc == MAX_W);
  assign capture   = (state == MEASURE) && rise;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = MEASURE;
      MEASURE: if (!rise && at_max) state_nxt = TIMEOUT;
      TIMEOUT: if (rise) state_nxt = MEASURE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    timeout = (state == TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case (state)
        MEASURE: begin
          if (rise)         count <= '0;
          else if (!at_max) count <= count_inc;
        end
        TIMEOUT: if (rise) count <= '0;
        default: count <= '0;
      endcase
    end
  end

  // A capture wins over an accept in the same cycle; overrun only when the old value was refused.
  always_ff @(posedge clk) begin
    if (reset) begin
      period       <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (capture) begin
      period       <= count_inc;
      period_valid <= 1'b1;
      if (period_valid && !period_ready) overrun <= 1'b1;
    end else if (period_valid && period_ready) begin
      period_valid <= 1'b0;
    end
  end

`ifdef PULSE_PERIOD_METER_MINMAX_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      min_period <= '1;
      max_period <= '0;
    end else if (capture) begin
      if (count_inc < min_period) min_period <= count_inc;
      if (count_inc > max_period) max_period <= count_inc;
    end
  end
`else
  assign min_period = '0;
  assign max_period = '0;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomised and directed checks of pulse_period_meter against a cycle-stamp reference model.
module tb_pulse_period_meter;

  localparam int W    = 20;
  localparam int MAXC = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pulse_in = 1'b0;
  logic         period_ready = 1'b0;
  logic [W-1:0] period, min_period, max_period;
  logic         period_valid, timeout, overrun;

  int total = 0;
  int bad   = 0;

  pulse_period_meter #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
    .clk          (clk),
    .reset        (reset),
    .pulse_in     (pulse_in),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .timeout      (timeout),
    .overrun      (overrun),
    .min_period   (min_period),
    .max_period   (max_period)
  );

  always #5 clk = ~clk;

  // Reference model: remembers the cycle number of the last edge and
  // derives period/timeout from cycle-number differences.
  longint       cyc = 0;
  longint       m_last = 0;
  bit           m_armed = 0, m_prev = 0;
  bit           m_vld = 0, m_ovr = 0, m_to = 0;
  logic [W-1:0] m_period = '0, m_min = '1, m_max = '0;

  task automatic model_update();
    bit     edge_seen, cap;
    longint diff;
    cyc++;
    if (reset) begin
      m_armed = 0; m_prev = 0; m_vld = 0; m_ovr = 0; m_to = 0;
      m_period = '0; m_min = '1; m_max = '0;
    end else begin
      edge_seen = pulse_in && !m_prev;
      m_prev    = pulse_in;
      cap       = 0;
      diff      = cyc - m_last;
      if (edge_seen) begin
        if (m_armed && diff <= MAXC) cap = 1;
        m_armed = 1;
        m_last  = cyc;
      end
      if (cap) begin
        if (m_vld && !period_ready) m_ovr = 1;
        m_period = W'(diff);
        m_vld    = 1;
        if (m_period < m_min) m_min = m_period;
        if (m_period > m_max) m_max = m_period;
      end else if (m_vld && period_ready) begin
        m_vld = 0;
      end
      m_to = m_armed && ((cyc - m_last) >= MAXC);
    end
  endtask

  function automatic logic [3*W+2:0] obs();
    return {period, period_valid, timeout, overrun, min_period, max_period};
  endfunction

  function automatic logic [3*W+2:0] expv();
`ifdef PULSE_PERIOD_METER_MINMAX_EN
    return {m_period, m_vld, m_to, m_ovr, m_min, m_max};
`else
    return {m_period, m_vld, m_to, m_ovr, {W{1'b0}}, {W{1'b0}}};
`endif
  endfunction

  // Drive one cycle of stimulus, clock it, then settle past the edge.
  task automatic drv(input logic p, input logic r);
    pulse_in     = p;
    period_ready = r;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(1'b0, 1'b0);
    drv(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] want_min;
`ifdef PULSE_PERIOD_METER_MINMAX_EN
    want_min = '1;
`else
    want_min = '0;
`endif
    do_reset();
    total++;
    if (obs() !== {{W{1'b0}}, 3'b000, want_min, {W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_values: got %h want %h", obs(), {{W{1'b0}}, 3'b000, want_min, {W{1'b0}}});
    end
  endtask

  task automatic test_periodic();
    do_reset();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 5; k++) begin
        drv(k == 0, 1'b1);
        total++;
        if (obs() !== expv()) begin
          bad++;
          $display("FAIL periodic_model e=%0d k=%0d: got %h want %h", e, k, obs(), expv());
        end
        if (e > 0 && k == 0) begin
          total++;
          if ({period, period_valid, overrun} !== {20'd5, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL periodic_value e=%0d: period=%0d vld=%b ovr=%b want 5/1/0", e, period, period_valid, overrun);
          end
        end
        if (e > 0 && k == 1) begin
          total++;
          if (period_valid !== 1'b0) begin
            bad++;
            $display("FAIL periodic_vld_drop e=%0d: vld=%b want 0", e, period_valid);
          end
        end
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 11; i++) drv(i % 5 == 0, 1'b0);
    total++;
    if ({period, period_valid, overrun} !== {20'd5, 1'b1, 1'b1} || obs() !== expv()) begin
      bad++;
      $display("FAIL overrun_set: period=%0d vld=%b ovr=%b want 5/1/1", period, period_valid, overrun);
    end
    drv(1'b0, 1'b1);
    total++;
    if ({period_valid, overrun} !== 2'b01) begin
      bad++;
      $display("FAIL overrun_accept: vld=%b ovr=%b want 0/1", period_valid, overrun);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drv(1'b1, 1'b1);
    for (int j = 1; j <= 20; j++) begin
      drv(1'b0, 1'b1);
      if (j == 15 || j == 16) begin
        total++;
        if (timeout !== (j == 16)) begin
          bad++;
          $display("FAIL timeout_onset j=%0d: timeout=%b want %b", j, timeout, j == 16);
        end
      end
    end
    drv(1'b1, 1'b1);
    total++;
    if ({timeout, period_valid} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_exit: timeout=%b vld=%b want 0/0", timeout, period_valid);
    end
    for (int j = 0; j < 6; j++) drv(1'b0, 1'b1);
    drv(1'b1, 1'b1);
    total++;
    if ({period, period_valid} !== {20'd7, 1'b1} || obs() !== expv()) begin
      bad++;
      $display("FAIL timeout_next_period: period=%0d vld=%b want 7/1", period, period_valid);
    end
  endtask

  task automatic test_minmax();
    int gaps[3] = '{3, 9, 4};
    logic [W-1:0] wmin, wmax;
    do_reset();
    drv(1'b1, 1'b1);
    foreach (gaps[g]) begin
      for (int j = 1; j < gaps[g]; j++) drv(1'b0, 1'b1);
      drv(1'b1, 1'b1);
    end
`ifdef PULSE_PERIOD_METER_MINMAX_EN
    wmin = 20'd3; wmax = 20'd9;
`else
    wmin = 20'd0; wmax = 20'd0;
`endif
    total++;
    if ({min_period, max_period} !== {wmin, wmax} || period !== 20'd4) begin
      bad++;
      $display("FAIL minmax: min=%0d max=%0d period=%0d want %0d/%0d/4", min_period, max_period, period, wmin, wmax);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drv(1'b1, 1'b1);
    drv(1'b0, 1'b1);
    drv(1'b0, 1'b1);
    reset = 1'b1;
    drv(1'b1, 1'b1);
    reset = 1'b0;
    total++;
    if (obs() !== expv() || {period, period_valid, timeout, overrun} !== {20'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset_mid_values: got %h want %h", obs(), expv());
    end
    drv(1'b0, 1'b1);
    drv(1'b1, 1'b1);
    total++;
    if (period_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_arm: vld=%b want 0", period_valid);
    end
    for (int j = 0; j < 5; j++) drv(1'b0, 1'b1);
    drv(1'b1, 1'b1);
    total++;
    if ({period, period_valid} !== {20'd6, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid_period: period=%0d vld=%b want 6/1", period, period_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int j = 0; j < 10; j++) begin
      drv(1'b1, 1'b0);
      total++;
      if (period_valid !== 1'b0) begin
        bad++;
        $display("FAIL level_hold j=%0d: vld=%b want 0", j, period_valid);
      end
    end
    drv(1'b0, 1'b0);
    drv(1'b0, 1'b0);
    drv(1'b1, 1'b0);
    total++;
    if ({period, period_valid} !== {20'd12, 1'b1}) begin
      bad++;
      $display("FAIL level_period: period=%0d vld=%b want 12/1", period, period_valid);
    end
    drv(1'b0, 1'b0);
    drv(1'b0, 1'b0);
    drv(1'b1, 1'b1);
    total++;
    if ({period, period_valid, overrun} !== {20'd3, 1'b1, 1'b0} || obs() !== expv()) begin
      bad++;
      $display("FAIL capture_with_accept: period=%0d vld=%b ovr=%b want 3/1/0", period, period_valid, overrun);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(199) == 0);
      drv($urandom_range(5) == 0, $urandom_range(1) == 1);
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL random i=%0d: got %h want %h", i, obs(), expv());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_overrun();
    test_timeout();
    test_minmax();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
